// File: rtl/gpr_scoreboard_pkg.sv
// Shared constants and types for the GPR write scoreboard.
// Holds GPR file geometry, the r0 index and the hazard-cause encoding.
// No logic; imported by the scoreboard and by debug trace consumers.
package gpr_scoreboard_pkg;

    localparam int GPR_NUM = 32;
    localparam int GPR_AW  = 5;

    // r0 reads as zero and is never a real write target.
    localparam logic [GPR_AW-1:0] GPR_R0 = '0;

    // Hazard causes; the value doubles as the bit index in the hazard vector.
    typedef enum logic [1:0] {
        HZ_RAW_A = 2'd0,
        HZ_RAW_B = 2'd1,
        HZ_WAW   = 2'd2,
        HZ_FULL  = 2'd3
    } hz_cause_e;

    localparam int HZ_NUM = 4;

    // One-hot decode of a register address.
    function automatic logic [GPR_NUM-1:0] gpr_onehot(input logic [GPR_AW-1:0] addr);
        logic [GPR_NUM-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Tracks GPRs awaiting a long-latency write-back and stalls dependent ID issue.
// Latency: stall is combinational (0 cycles); pending/outstanding/busy/wb_err update on the next clk edge.
// Backpressure: stall holds ID on RAW/WAW/FULL hazards; write-back is never back-pressured.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   rs_*/rt_*                   ID source operands and their use flags
//   issue_valid/long/waddr      ID instruction and its long-latency destination
//   flush                       kills the ID instruction this cycle
//   wb_valid/wb_waddr           long-latency write-back retiring a register
//   stall                       combinational ID hold
//   busy                        registered: at least one write outstanding
//   wb_err                      sticky: bad write-back (r0, non-pending, or counter empty)
//   stall_cycles                stall counter, only when GPR_SB_STATS_EN is defined
module gpr_scoreboard
    import gpr_scoreboard_pkg::*;
#(
    parameter int LONG_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [GPR_AW-1:0] rs_addr,
    input  logic              rs_used,
    input  logic [GPR_AW-1:0] rt_addr,
    input  logic              rt_used,
    input  logic              issue_valid,
    input  logic              issue_long,
    input  logic [GPR_AW-1:0] issue_waddr,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [GPR_AW-1:0] wb_waddr,
    output logic              stall,
    output logic              busy,
`ifdef GPR_SB_STATS_EN
    output logic              wb_err,
    output logic [31:0]       stall_cycles
`else
    output logic              wb_err
`endif
);

    localparam logic [3:0] LONG_MAX_C = 4'(LONG_MAX);

    logic [GPR_NUM-1:0] r_pending;
    logic [3:0]         r_outstanding;
    logic               r_busy;
    logic               r_wb_err;

    logic [GPR_NUM-1:0] w_wb_hot;
    logic [GPR_NUM-1:0] w_eff_pending;
    logic               w_wb_dec;
    logic [3:0]         w_out_eff;
    logic [HZ_NUM-1:0]  w_hz;
    logic               w_id_live;
    logic               w_stall;
    logic               w_accept;
    logic               w_wb_bad;
    logic [GPR_NUM-1:0] w_pending_nxt;
    logic [3:0]         w_out_nxt;

    // A same-cycle write-back is treated as retired: the bypass forwards it.
    assign w_wb_hot      = wb_valid ? gpr_onehot(wb_waddr) : '0;
    assign w_eff_pending = r_pending & ~w_wb_hot;

    // Decrement only when something is outstanding so the counter never wraps;
    // this also keeps a stray write-back from faking a FULL match at LONG_MAX=15.
    assign w_wb_dec  = wb_valid & (r_outstanding != 4'd0);
    assign w_out_eff = r_outstanding - {3'd0, w_wb_dec};

    always_comb begin
        w_hz           = '0;
        w_hz[HZ_RAW_A] = rs_used & (rs_addr != GPR_R0) & w_eff_pending[rs_addr];
        w_hz[HZ_RAW_B] = rt_used & (rt_addr != GPR_R0) & w_eff_pending[rt_addr];
        w_hz[HZ_WAW]   = issue_long & (issue_waddr != GPR_R0) & w_eff_pending[issue_waddr];
        w_hz[HZ_FULL]  = issue_long & (w_out_eff == LONG_MAX_C);
    end

    assign w_id_live = issue_valid & ~flush;
    assign w_stall   = w_id_live & (|w_hz);
    assign w_accept  = w_id_live & ~w_stall & issue_long & (issue_waddr != GPR_R0);

    assign w_wb_bad = wb_valid & ((wb_waddr == GPR_R0) | ~r_pending[wb_waddr] |
                                  (r_outstanding == 4'd0));

    // Clear on write-back first, then set on accept so a same-register
    // retire-and-reissue leaves the bit set. r0 is forced clear.
    always_comb begin
        w_pending_nxt = r_pending & ~w_wb_hot;
        if (w_accept) begin
            w_pending_nxt = w_pending_nxt | gpr_onehot(issue_waddr);
        end
        w_pending_nxt[GPR_R0] = 1'b0;
    end

    assign w_out_nxt = r_outstanding + {3'd0, w_accept} - {3'd0, w_wb_dec};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending     <= '0;
            r_outstanding <= 4'd0;
            r_busy        <= 1'b0;
            r_wb_err      <= 1'b0;
        end else begin
            r_pending     <= w_pending_nxt;
            r_outstanding <= w_out_nxt;
            r_busy        <= (w_out_nxt != 4'd0);
            if (w_wb_bad) begin
                r_wb_err <= 1'b1;
            end
        end
    end

`ifdef GPR_SB_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
        end else if (w_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign stall  = w_stall;
    assign busy   = r_busy;
    assign wb_err = r_wb_err;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed self-checking bench for gpr_scoreboard (LONG_MAX = 4).
// Inputs change 1 time unit after the rising edge; the combinational stall is
// checked 1 unit later, registered outputs are checked after the following edge.
module tb_gpr_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_addr;
    logic        rs_used;
    logic [4:0]  rt_addr;
    logic        rt_used;
    logic        issue_valid;
    logic        issue_long;
    logic [4:0]  issue_waddr;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_waddr;
    logic        stall;
    logic        busy;
    logic        wb_err;
`ifdef GPR_SB_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    gpr_scoreboard #(.LONG_MAX(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_addr     (rs_addr),
        .rs_used     (rs_used),
        .rt_addr     (rt_addr),
        .rt_used     (rt_used),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_waddr (issue_waddr),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_waddr    (wb_waddr),
        .stall       (stall),
        .busy        (busy),
`ifdef GPR_SB_STATS_EN
        .wb_err      (wb_err),
        .stall_cycles(stall_cycles)
`else
        .wb_err      (wb_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic idle();
        rs_addr     = 5'd0;
        rs_used     = 1'b0;
        rt_addr     = 5'd0;
        rt_used     = 1'b0;
        issue_valid = 1'b0;
        issue_long  = 1'b0;
        issue_waddr = 5'd0;
        flush       = 1'b0;
        wb_valid    = 1'b0;
        wb_waddr    = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] wa);
        issue_valid = 1'b1;
        issue_long  = 1'b1;
        issue_waddr = wa;
    endtask

    task automatic wb(input logic [4:0] wa);
        wb_valid = 1'b1;
        wb_waddr = wa;
    endtask

    initial begin
        logic [4:0] drain [4];
        drain[0] = 5'd2; drain[1] = 5'd3; drain[2] = 5'd4; drain[3] = 5'd9;

        // Reset with hazardous-looking inputs applied.
        idle();
        reset = 1'b1;
        issue(5'd5);
        rs_addr = 5'd5; rs_used = 1'b1;
        wb(5'd3);
        tick(); tick();
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
        chk("rst_outstanding", {28'd0, dut.r_outstanding}, 32'd0);
        idle();
        reset = 1'b0;
        tick();

        // RAW-A: long issue to r5, dependent read stalls until write-back.
        issue(5'd5);
        #1 chk("raw_issue_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();
        chk("raw_busy", {31'd0, busy}, 32'd1);
        issue_valid = 1'b1; rs_addr = 5'd5; rs_used = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1 chk($sformatf("raw_a_stall_c%0d", c), {31'd0, stall}, 32'd1);
            tick();
        end
        wb(5'd5);
        #1 chk("raw_a_wb_same_cycle", {31'd0, stall}, 32'd0);
        tick();
        wb_valid = 1'b0;
        #1 chk("raw_a_after_wb", {31'd0, stall}, 32'd0);
        chk("raw_pending5", {31'd0, dut.r_pending[5]}, 32'd0);
        chk("raw_busy_clear", {31'd0, busy}, 32'd0);
        tick();

        // Long issue to r0 is never recorded; r0 reads never stall.
        idle();
        issue(5'd0);
        #1 chk("r0_issue_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();
        chk("r0_busy", {31'd0, busy}, 32'd0);
        issue_valid = 1'b1;
        rs_addr = 5'd0; rs_used = 1'b1; rt_addr = 5'd0; rt_used = 1'b1;
        #1 chk("r0_read_stall", {31'd0, stall}, 32'd0);
        tick();

        // RAW-B and WAW on r7, then same-cycle write-back lets the reissue in.
        idle();
        issue(5'd7);
        tick();
        idle();
        chk("waw_busy", {31'd0, busy}, 32'd1);
        issue_valid = 1'b1; rt_addr = 5'd7; rt_used = 1'b1;
        #1 chk("raw_b_stall", {31'd0, stall}, 32'd1);
        rt_used = 1'b0;
        issue(5'd7);
        #1 chk("waw_stall", {31'd0, stall}, 32'd1);
        tick();
        wb(5'd7);
        #1 chk("waw_wb_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();
        chk("waw_pending7", {31'd0, dut.r_pending[7]}, 32'd1);
        chk("waw_outstanding", {28'd0, dut.r_outstanding}, 32'd1);
        chk("waw_wb_err", {31'd0, wb_err}, 32'd0);
        wb(5'd7);
        tick();
        idle();
        chk("waw_drained_busy", {31'd0, busy}, 32'd0);

        // FULL at LONG_MAX = 4, relieved by a same-cycle write-back.
        for (int r = 1; r <= 4; r++) begin
            issue(5'(r));
            #1 chk($sformatf("fill_r%0d_stall", r), {31'd0, stall}, 32'd0);
            tick();
        end
        idle();
        chk("full_outstanding", {28'd0, dut.r_outstanding}, 32'd4);
        issue_valid = 1'b1;
        #1 chk("full_short_issue_stall", {31'd0, stall}, 32'd0);
        issue(5'd9);
        #1 chk("full_stall", {31'd0, stall}, 32'd1);
        wb(5'd1);
        #1 chk("full_wb_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();
        chk("full_outstanding_kept", {28'd0, dut.r_outstanding}, 32'd4);
        chk("full_pending9", {31'd0, dut.r_pending[9]}, 32'd1);
        chk("full_pending1", {31'd0, dut.r_pending[1]}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            wb(drain[i]);
            tick();
        end
        idle();
        chk("full_drained_busy", {31'd0, busy}, 32'd0);
        chk("full_drained_err", {31'd0, wb_err}, 32'd0);

        // Flush kills a hazardous issue; it is not recorded.
        issue(5'd6);
        tick();
        idle();
        issue(5'd6);
        rs_addr = 5'd6; rs_used = 1'b1; flush = 1'b1;
        #1 chk("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();
        chk("flush_outstanding", {28'd0, dut.r_outstanding}, 32'd1);
        wb(5'd6);
        tick();
        idle();
        chk("flush_drained_busy", {31'd0, busy}, 32'd0);
        chk("flush_no_err", {31'd0, wb_err}, 32'd0);

        // Write-back to unpended r12 sets sticky wb_err; counter stays at 0.
        wb(5'd12);
        tick();
        idle();
        chk("err_set", {31'd0, wb_err}, 32'd1);
        chk("err_outstanding_sat", {28'd0, dut.r_outstanding}, 32'd0);
        tick(); tick();
        chk("err_sticky", {31'd0, wb_err}, 32'd1);

        // Reset mid-operation drops tracking and the error.
        issue(5'd8);
        tick();
        idle();
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_err", {31'd0, wb_err}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        issue_valid = 1'b1; rs_addr = 5'd8; rs_used = 1'b1;
        #1 chk("midrst_read_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();

`ifdef GPR_SB_STATS_EN
        // Counter reflects exactly three stalled cycles, then clears on reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        issue(5'd10);
        tick();
        idle();
        issue_valid = 1'b1; rs_addr = 5'd10; rs_used = 1'b1;
        tick(); tick(); tick();
        idle();
        chk("stats_count", stall_cycles, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("stats_reset", stall_cycles, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gpr_scoreboard.md
# gpr_scoreboard

Register-level write tracker for the GPR pipeline: it records which GPRs have an outstanding result from a long-latency producer (load, multiply/divide) that the EXE-stage bypass cannot yet forward. It raises an ID-stage stall until the producer's write-back retires the register. It sits beside the ID-stage bypass mux, is updated by the write-back port, and is the writer-side counterpart of the operand bypass.

## Interface
- `LONG_MAX`, default 4: maximum simultaneously outstanding long-latency writes, 1..15.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `rs_addr`  in  5  ID source register A.
- `rs_used`  in  1  ID instruction reads `rs_addr`.
- `rt_addr`  in  5  ID source register B.
- `rt_used`  in  1  ID instruction reads `rt_addr`.
- `issue_valid`  in  1  ID instruction is valid this cycle.
- `issue_long`  in  1  ID instruction writes its GPR through the long-latency path.
- `issue_waddr`  in  5  ID destination GPR.
- `flush`  in  1  kill the ID instruction this cycle; it is never recorded.
- `wb_valid`  in  1  long-latency result written to the GPR file this cycle.
- `wb_waddr`  in  5  GPR written by that result.
- `stall`  out  1  hold ID; combinational.
- `busy`  out  1  at least one write outstanding; registered.
- `wb_err`  out  1  sticky error: write-back to a non-pending register or counter underflow.
- `stall_cycles`  out  32  stall counter; present only with `GPR_SB_STATS_EN`.

## Operation
- State: `pending[31:1]` bits (r0 hardwired clear) and `outstanding` counter, 4 bits.
- `eff_pending[r] = pending[r] & ~(wb_valid & wb_waddr == r)`. A same-cycle write-back counts as already retired because the bypass forwards it.
- Hazard terms:
  - RAW-A: `rs_used & rs_addr != 0 & eff_pending[rs_addr]`.
  - RAW-B: same for `rt_addr`.
  - WAW: `issue_long & issue_waddr != 0 & eff_pending[issue_waddr]`.
  - FULL: `issue_long & outstanding_eff == LONG_MAX`, where `outstanding_eff = outstanding - wb_valid`.
- `stall = issue_valid & ~flush & (RAW-A | RAW-B | WAW | FULL)`.
- Accept = `issue_valid & ~flush & ~stall & issue_long & issue_waddr != 0`.
- On a clock edge:
  - Clear `pending[wb_waddr]` if `wb_valid`.
  - Then set `pending[issue_waddr]` on Accept; set wins on the same register.
  - `outstanding += Accept - wb_valid`.
- Write-back to r0, to a non-pending register, or with `outstanding == 0`:
  - Set `wb_err`; it clears only on reset.
  - Counter saturates at 0; the pending bit is unchanged.
- `flush` never cancels already-accepted writes; they still retire through `wb_valid`.
- `busy = (outstanding != 0)`, registered.

## Timing
- Reset values: all `pending` = 0, `outstanding` = 0, `busy` = 0, `wb_err` = 0, `stall_cycles` = 0.
- `stall` is 0 during reset because of the state values, regardless of inputs.
- `stall` has zero latency: it depends combinationally on the ID and write-back inputs of the same cycle.
- Accepted issue in cycle N: a dependent ID read in cycle N+1 stalls. The stall drops in the cycle its `wb_valid` arrives.
- Reset asserted mid-operation discards all outstanding tracking. The producer is reset in the same cycle.
- `LONG_MAX` boundary: with the counter full and a simultaneous `wb_valid`, a new long issue is accepted and the counter stays at `LONG_MAX`.

## Configuration
- `GPR_SB_STATS_EN` defined:
  - `stall_cycles` increments every cycle `stall` = 1.
  - It wraps at 2^32 and resets to 0.
- Undefined: the port and counter are absent. No other behaviour changes.

## Structure
- Shared package/header holds:
  - `GPR_NUM` = 32 and `GPR_AW` = 5.
  - The r0 index constant.
  - The hazard-cause encoding (RAW_A, RAW_B, WAW, FULL), used by debug trace.
- No sub-module needed. The pending vector and the hazard logic stay in one module.

## Test plan
- Long issue to r5 in cycle 0. In cycle 1 `rs_addr` = 5, `rs_used` = 1 → `stall` = 1 until `wb_valid`/`wb_waddr` = 5 arrive in cycle 4. `stall` = 0 in cycle 4 and `pending[5]` = 0 after.
- Long issue to r0 → never recorded; `busy` stays 0. A later read of r0 never stalls.
- Pending r7 with a second long issue to r7 → WAW stall. The same-cycle `wb_valid` for r7 → accepted, `pending[7]` = 1 afterwards.
- Four accepted long issues to r1..r4 (`LONG_MAX` = 4), then a long issue to r9 → FULL stall. With `wb_valid` for r1 the same cycle → accepted and `outstanding` stays 4.
- `flush` = 1 with a hazardous issue → `stall` = 0 and nothing recorded. `wb_valid` for unpended r12 → `wb_err` = 1 and held until `reset`.
- Stats build: 3 stall cycles, then `reset` → `stall_cycles` reads 3, then 0 after reset.
